imm_ext_arbiter: RTL and testbench
==================================

# imm_ext_arbiter

Shared immediate-extension unit with a two-requester round-robin arbiter and a one-entry registered output stage. Requester A is the decode path (I-type operands). Requester B is the branch/jump target path. Each requester presents a 16-bit immediate and an extension mode. The block grants one requester per cycle, extends the immediate to 32 bits, and holds the result in an output register until the consumer accepts it.

## Interface
Parameters:
- none (widths fixed: 16-bit immediate in, 32-bit data out)

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high; sampled on the rising edge of CLK
- ReqA  in  1  requester A holds an operand; held high until GntA
- ImmA  in  16  requester A immediate
- ModeA  in  2  requester A mode: 00 zero-ext, 01 sign-ext, 10 upper (LUI), 11 branch offset
- GntA  out  1  combinational; A's operand is accepted this cycle
- ReqB, ImmB, ModeB, GntB  same as the A-side ports, for requester B
- DataOut  out  32  extended result, registered
- OutValid  out  1  DataOut is valid
- OutId  out  1  source of DataOut: 0 = A, 1 = B
- OutReady  in  1  consumer accepts DataOut this cycle when OutValid is high
- ContCnt  out  16  contention-cycle counter (see Configuration)

## Operation
- Free = !OutValid || OutReady. New data is accepted only when Free is high.
- Arbitration, evaluated only when Free is high:
  - Only ReqA high: grant A.
  - Only ReqB high: grant B.
  - Both high: grant the requester not recorded in LastGnt.
  - Neither high: no grant.
- When Free is low: GntA = GntB = 0, and requests wait.
- LastGnt updates to the granted requester on each grant. Reset value of LastGnt is B, so A wins the first contention.
- Extension of the selected Imm by mode:
  - 00: {16'b0, Imm}
  - 01: {{16{Imm[15]}}, Imm}
  - 10: {Imm, 16'b0}
  - 11: {{14{Imm[15]}}, Imm, 2'b00}
- On a grant: DataOut is loaded with the extension result, OutId with the winner, and OutValid is set to 1.
- On OutReady with OutValid high and no grant in the same cycle: OutValid clears. DataOut and OutId hold their last values.
- On OutReady with OutValid high and a grant in the same cycle: the register is overwritten and OutValid stays 1 (back-to-back throughput).
- OutReady while OutValid is low is ignored.
- ImmX and ModeX are don't-care when ReqX is low. A requester must not change ImmX or ModeX while ReqX is high and GntX is low.

## Timing
- Latency: a grant in cycle t gives OutValid and DataOut in cycle t+1.
- Throughput: one result per cycle when OutReady is held high.
- GntA and GntB are never high together, and both are 0 while Reset is high.
- Backpressure: when OutValid=1 and OutReady=0, both grants stay low and DataOut, OutId and OutValid hold.
- Reset values: OutValid=0, DataOut=32'h0, OutId=0, LastGnt=B, ContCnt=0.
- Reset mid-operation: a pending result is discarded, and a request active in the reset cycle is not granted in that cycle. A request still held after Reset is deasserted is re-arbitrated normally.

## Configuration
- IMM_EXT_CONTENTION_CNT_EN defined:
  - ContCnt increments by 1 on every non-reset cycle where ReqA && ReqB.
  - It saturates at 16'hFFFF and clears only on Reset.
- IMM_EXT_CONTENTION_CNT_EN undefined: ContCnt is tied to 16'h0 and no counter logic is built. Arbitration behaviour is identical in both builds.

## Test plan
- Single requests per mode: ReqA with ImmA=16'h8001.
  - ModeA=00 -> DataOut=32'h00008001
  - ModeA=01 -> 32'hFFFF8001
  - ModeA=10 -> 32'h80010000
  - ModeA=11 -> 32'hFFFE0004
  - Each result arrives 1 cycle after GntA, with OutId=0.
- Round-robin: ReqA and ReqB held high for 4 cycles with OutReady=1.
  - Grants go A,B,A,B; OutId sequence is 0,1,0,1.
  - ContCnt=4 with the macro defined, 0 without it.
- Backpressure: result pending and OutReady=0 for 3 cycles while ReqB is high.
  - GntB stays low and DataOut is stable.
  - OutReady rises -> GntB in that same cycle, and the new DataOut appears in the next cycle.
- Drain: single grant, then OutReady=1 with no requests.
  - OutValid clears in the following cycle; DataOut holds its value.
- Reset mid-flight: Reset asserted while OutValid=1 and ReqA is high.
  - Next cycle: OutValid=0, ContCnt=0, no grant.
  - After Reset falls, with A and B both requesting, A wins first.
- Saturation (macro defined): preload via 65540 contention cycles -> ContCnt=16'hFFFF and it holds there.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
// Shared immediate-extension unit. Two requesters (A = decode path, B = branch
// target path) are arbitrated round-robin. The granted immediate is extended
// to 32 bits and held in a one-entry output register until the consumer takes it.
// Optional build macro: IMM_EXT_CONTENTION_CNT_EN enables the saturating
// contention-cycle counter on ContCnt. When undefined, ContCnt is tied to zero.

module imm_ext_arbiter (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqA,
    input  logic [15:0] ImmA,
    input  logic [1:0]  ModeA,
    output logic        GntA,
    input  logic        ReqB,
    input  logic [15:0] ImmB,
    input  logic [1:0]  ModeB,
    output logic        GntB,
    output logic [31:0] DataOut,
    output logic        OutValid,
    output logic        OutId,
    input  logic        OutReady,
    output logic [15:0] ContCnt
);

    // Requester encoding shared by LastGnt and OutId.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic        lastGnt_r;
    logic [31:0] dataOut_r;
    logic        outValid_r;
    logic        outId_r;

    logic        free_s;
    logic        gntA_s;
    logic        gntB_s;
    logic [15:0] selImm_s;
    logic [1:0]  selMode_s;
    logic [31:0] extData_s;

    // Immediate extension by mode; branch offsets are word-aligned, hence the shift by two.
    function automatic logic [31:0] extendImm(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] res;
        case (mode)
            2'b00:   res = {16'h0000, imm};
            2'b01:   res = {{16{imm[15]}}, imm};
            2'b10:   res = {imm, 16'h0000};
            2'b11:   res = {{14{imm[15]}}, imm, 2'b00};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Arbitration: only when the output slot is free, never during reset; on contention the requester not granted last wins.
    always_comb begin
        free_s = !outValid_r || OutReady;
        gntA_s = 1'b0;
        gntB_s = 1'b0;
        if (!Reset && free_s) begin
            gntA_s = ReqA && (!ReqB || (lastGnt_r == SRC_B));
            gntB_s = ReqB && (!ReqA || (lastGnt_r == SRC_A));
        end else begin
            gntA_s = 1'b0;
            gntB_s = 1'b0;
        end
    end

    // Operand select for the extension datapath, driven by the winning grant.
    always_comb begin
        selImm_s  = ImmA;
        selMode_s = ModeA;
        if (gntB_s) begin
            selImm_s  = ImmB;
            selMode_s = ModeB;
        end else begin
            selImm_s  = ImmA;
            selMode_s = ModeA;
        end
        extData_s = extendImm(selImm_s, selMode_s);
    end

    // One-entry output register and round-robin history; a grant always wins over a plain drain.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            lastGnt_r  <= SRC_B;
            dataOut_r  <= 32'h0000_0000;
            outValid_r <= 1'b0;
            outId_r    <= SRC_A;
        end else if (gntA_s || gntB_s) begin
            lastGnt_r  <= gntB_s ? SRC_B : SRC_A;
            dataOut_r  <= extData_s;
            outValid_r <= 1'b1;
            outId_r    <= gntB_s ? SRC_B : SRC_A;
        end else if (outValid_r && OutReady) begin
            outValid_r <= 1'b0;
        end
    end

`ifdef IMM_EXT_CONTENTION_CNT_EN
    logic [15:0] contCnt_r;

    // Saturating count of cycles in which both requesters are asking at once.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            contCnt_r <= 16'h0000;
        end else if (ReqA && ReqB && (contCnt_r != 16'hFFFF)) begin
            contCnt_r <= contCnt_r + 16'h0001;
        end
    end

    assign ContCnt = contCnt_r;
`else
    assign ContCnt = 16'h0000;
`endif

    assign GntA     = gntA_s;
    assign GntB     = gntB_s;
    assign DataOut  = dataOut_r;
    assign OutValid = outValid_r;
    assign OutId    = outId_r;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter
// Directed-vector bench for imm_ext_arbiter with hand-computed expectations.
// Define IMM_EXT_CONTENTION_CNT_EN to match a DUT built with the contention counter.

module tb_imm_ext_arbiter;

    logic        CLK;
    logic        Reset;
    logic        ReqA;
    logic [15:0] ImmA;
    logic [1:0]  ModeA;
    logic        GntA;
    logic        ReqB;
    logic [15:0] ImmB;
    logic [1:0]  ModeB;
    logic        GntB;
    logic [31:0] DataOut;
    logic        OutValid;
    logic        OutId;
    logic        OutReady;
    logic [15:0] ContCnt;

    int vecCnt;
    int errCnt;

`ifdef IMM_EXT_CONTENTION_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    imm_ext_arbiter dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .ReqA     (ReqA),
        .ImmA     (ImmA),
        .ModeA    (ModeA),
        .GntA     (GntA),
        .ReqB     (ReqB),
        .ImmB     (ImmB),
        .ModeB    (ModeB),
        .GntB     (GntB),
        .DataOut  (DataOut),
        .OutValid (OutValid),
        .OutId    (OutId),
        .OutReady (OutReady),
        .ContCnt  (ContCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every vector and reports any miscompare.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt = vecCnt + 1;
        if (obs !== exp) begin
            errCnt = errCnt + 1;
            $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; registered outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational grants settle after an input change, well clear of the edge.
    task automatic settle();
        #1;
    endtask

    logic [31:0] modeExp [4];
    logic [31:0] expCnt;

    initial begin
        vecCnt = 0;
        errCnt = 0;
        modeExp[0] = 32'h0000_8001;
        modeExp[1] = 32'hFFFF_8001;
        modeExp[2] = 32'h8001_0000;
        modeExp[3] = 32'hFFFE_0004;

        Reset = 1'b1; ReqA = 1'b1; ImmA = 16'h0000; ModeA = 2'b00;
        ReqB = 1'b0; ImmB = 16'h0000; ModeB = 2'b00; OutReady = 1'b0;
        settle();
        checkVal("gntA_in_reset", {31'd0, GntA}, 32'd0);
        step();
        step();
        ReqA = 1'b0;
        Reset = 1'b0;
        settle();
        checkVal("rst_outvalid", {31'd0, OutValid}, 32'd0);
        checkVal("rst_dataout", DataOut, 32'h0000_0000);
        checkVal("rst_outid", {31'd0, OutId}, 32'd0);
        checkVal("rst_contcnt", {16'd0, ContCnt}, 32'd0);

        // Single A requests through every extension mode, back to back.
        OutReady = 1'b1;
        for (int m = 0; m < 4; m++) begin
            ReqA = 1'b1; ImmA = 16'h8001; ModeA = m[1:0];
            settle();
            checkVal($sformatf("mode%0d_gntA", m), {31'd0, GntA}, 32'd1);
            checkVal($sformatf("mode%0d_gntB", m), {31'd0, GntB}, 32'd0);
            step();
            ReqA = 1'b0;
            checkVal($sformatf("mode%0d_valid", m), {31'd0, OutValid}, 32'd1);
            checkVal($sformatf("mode%0d_data", m), DataOut, modeExp[m]);
            checkVal($sformatf("mode%0d_id", m), {31'd0, OutId}, 32'd0);
        end

        // Drain: nothing requested, consumer ready.
        step();
        checkVal("drain_valid", {31'd0, OutValid}, 32'd0);
        checkVal("drain_data_hold", DataOut, 32'hFFFE_0004);
        checkVal("drain_id_hold", {31'd0, OutId}, 32'd0);

        // Single B request; leaves LastGnt on B before the contention run.
        ReqB = 1'b1; ImmB = 16'h1234; ModeB = 2'b01;
        settle();
        checkVal("singleB_gntB", {31'd0, GntB}, 32'd1);
        step();
        ReqB = 1'b0;
        checkVal("singleB_data", DataOut, 32'h0000_1234);
        checkVal("singleB_id", {31'd0, OutId}, 32'd1);

        // Round robin: both requesting for four cycles, expect A,B,A,B.
        ReqA = 1'b1; ImmA = 16'h0001; ModeA = 2'b00;
        ReqB = 1'b1; ImmB = 16'h0002; ModeB = 2'b00;
        for (int i = 0; i < 4; i++) begin
            settle();
            checkVal($sformatf("rr%0d_gntA", i), {31'd0, GntA}, (i % 2 == 0) ? 32'd1 : 32'd0);
            checkVal($sformatf("rr%0d_gntB", i), {31'd0, GntB}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            checkVal($sformatf("rr%0d_id", i), {31'd0, OutId}, (i % 2 == 0) ? 32'd0 : 32'd1);
            checkVal($sformatf("rr%0d_data", i), DataOut, (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        ReqA = 1'b0; ReqB = 1'b0;
        expCnt = CNT_EN ? 32'd4 : 32'd0;
        checkVal("rr_contcnt", {16'd0, ContCnt}, expCnt);

        // Backpressure: result pending from B, consumer stalls for three cycles.
        OutReady = 1'b0;
        ReqB = 1'b1; ImmB = 16'hFFFF; ModeB = 2'b10;
        for (int i = 0; i < 3; i++) begin
            settle();
            checkVal($sformatf("bp%0d_gntB", i), {31'd0, GntB}, 32'd0);
            step();
            checkVal($sformatf("bp%0d_data", i), DataOut, 32'h0000_0002);
            checkVal($sformatf("bp%0d_valid", i), {31'd0, OutValid}, 32'd1);
        end
        OutReady = 1'b1;
        settle();
        checkVal("bp_release_gntB", {31'd0, GntB}, 32'd1);
        step();
        ReqB = 1'b0;
        checkVal("bp_release_data", DataOut, 32'hFFFF_0000);
        checkVal("bp_release_id", {31'd0, OutId}, 32'd1);
        checkVal("bp_release_valid", {31'd0, OutValid}, 32'd1);

        // Reset mid-flight with a pending result and both requesters active.
        OutReady = 1'b0;
        Reset = 1'b1; ReqA = 1'b1; ImmA = 16'h0055; ModeA = 2'b00; ReqB = 1'b1;
        settle();
        checkVal("midrst_gntA", {31'd0, GntA}, 32'd0);
        checkVal("midrst_gntB", {31'd0, GntB}, 32'd0);
        step();
        checkVal("midrst_valid", {31'd0, OutValid}, 32'd0);
        checkVal("midrst_contcnt", {16'd0, ContCnt}, 32'd0);
        checkVal("midrst_data", DataOut, 32'h0000_0000);
        Reset = 1'b0; OutReady = 1'b1;
        settle();
        checkVal("postrst_gntA", {31'd0, GntA}, 32'd1);
        checkVal("postrst_gntB", {31'd0, GntB}, 32'd0);
        step();
        checkVal("postrst_id", {31'd0, OutId}, 32'd0);
        checkVal("postrst_data", DataOut, 32'h0000_0055);
        expCnt = CNT_EN ? 32'd1 : 32'd0;
        checkVal("postrst_contcnt", {16'd0, ContCnt}, expCnt);

`ifdef IMM_EXT_CONTENTION_CNT_EN
        // Saturation: keep both requesting well past the counter's range.
        for (int i = 0; i < 65540; i++) begin
            @(posedge CLK);
        end
        #1;
        checkVal("sat_contcnt", {16'd0, ContCnt}, 32'h0000_FFFF);
        step();
        step();
        checkVal("sat_hold", {16'd0, ContCnt}, 32'h0000_FFFF);
`endif
        ReqA = 1'b0; ReqB = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
